// File: rtl/snake_segment_writer.sv
// Walks a snapshot of the snake body and emits one board write per segment.
// Ports: start/erase/snake_len/snake_in in; wr_valid/wr_ready beat; busy/done.
module snake_segment_writer #(
  parameter int COORD_W = 4,
  parameter int MAX_LEN = 225,
  parameter int LEN_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           erase,
  input  logic [LEN_W-1:0]               snake_len,
  input  logic [MAX_LEN*2*COORD_W-1:0]   snake_in,
  output logic                           wr_valid,
  input  logic                           wr_ready,
  output logic [COORD_W-1:0]             x_loc,
  output logic [COORD_W-1:0]             y_loc,
  output logic [1:0]                     data_out,
  output logic [LEN_W-1:0]               seg_idx,
  output logic                           busy,
  output logic                           done
);

  localparam int SEG_W = 2 * COORD_W;
  localparam int VEC_W = MAX_LEN * SEG_W;
  localparam int IDX_W = $clog2(VEC_W);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [VEC_W-1:0]   snap;
  logic [VEC_W-1:0]   src;
  logic [LEN_W-1:0]   len, len_n, idx_n, clamp_len;
  logic               erase_q, erase_n, load;
  logic               valid_n, done_n;
  logic [COORD_W-1:0] x_n, y_n;
  logic [1:0]         data_n;
  logic [SEG_W-1:0]   seg;
  logic [IDX_W-1:0]   base;

  assign clamp_len = (snake_len > LEN_W'(MAX_LEN))
                   ? LEN_W'(MAX_LEN) : snake_len;

  // The first beat is launched in the same edge that takes the
  // snapshot, so it must read the live input rather than the register.
  assign src = (state == IDLE) ? snake_in : snap;

  always_comb begin
    state_n = state;
    idx_n   = seg_idx;
    len_n   = len;
    erase_n = erase_q;
    load    = 1'b0;
    valid_n = 1'b0;
    done_n  = 1'b0;
    data_n  = 2'b00;
    x_n     = x_loc;
    y_n     = y_loc;
    seg     = '0;
    base    = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          len_n   = clamp_len;
          erase_n = erase;
          idx_n   = '0;
          if (clamp_len == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = EMIT;
            valid_n = 1'b1;
          end
        end
      end
      EMIT: begin
        valid_n = 1'b1;
        if (wr_ready) begin
          if (seg_idx == len - 1'b1) begin
            state_n = DONE;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n = seg_idx + 1'b1;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (valid_n) begin
      base   = IDX_W'(idx_n) * IDX_W'(SEG_W);
      seg    = src[base +: SEG_W];
      x_n    = seg[COORD_W-1:0];
      y_n    = seg[SEG_W-1:COORD_W];
      data_n = erase_n ? 2'b00
             : ((idx_n == '0) ? 2'b11 : 2'b10);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap     <= '0;
      len      <= '0;
      erase_q  <= 1'b0;
      wr_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      x_loc    <= '0;
      y_loc    <= '0;
      data_out <= 2'b00;
      seg_idx  <= '0;
    end else begin
      if (load) snap <= snake_in;
      len      <= len_n;
      erase_q  <= erase_n;
      wr_valid <= valid_n;
      busy     <= (state_n != IDLE);
      done     <= done_n;
      x_loc    <= x_n;
      y_loc    <= y_n;
      data_out <= data_n;
      seg_idx  <= idx_n;
    end
  end

endmodule

// File: tb/tb_snake_segment_writer.sv
// Scoreboard bench for snake_segment_writer.
// Instance a: default params; instance b: COORD_W=5, MAX_LEN=4.
module tb_snake_segment_writer;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [1:0] code;
    logic [7:0] idx;
  } beat_t;

  logic          clk, rst_n;
  logic          start, erase, wr_ready;
  logic [7:0]    snake_len;
  logic [1799:0] snake_in;
  logic          a_valid, a_busy, a_done;
  logic [3:0]    a_x, a_y;
  logic [1:0]    a_data;
  logic [7:0]    a_idx;

  logic          b_start, b_erase, b_ready;
  logic [3:0]    b_len;
  logic [39:0]   b_in;
  logic          b_valid, b_busy, b_done;
  logic [4:0]    b_x, b_y;
  logic [1:0]    b_data;
  logic [3:0]    b_idx;

  beat_t sb[$];
  beat_t e;
  int n_checks = 0;
  int n_fail = 0;
  int hs_a = 0;
  int done_a = 0;

  snake_segment_writer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .erase(erase),
    .snake_len(snake_len), .snake_in(snake_in),
    .wr_valid(a_valid), .wr_ready(wr_ready),
    .x_loc(a_x), .y_loc(a_y), .data_out(a_data),
    .seg_idx(a_idx), .busy(a_busy), .done(a_done)
  );

  snake_segment_writer #(.COORD_W(5), .MAX_LEN(4), .LEN_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .erase(b_erase),
    .snake_len(b_len), .snake_in(b_in),
    .wr_valid(b_valid), .wr_ready(b_ready),
    .x_loc(b_x), .y_loc(b_y), .data_out(b_data),
    .seg_idx(b_idx), .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_valid && wr_ready) hs_a <= hs_a + 1;
    if (a_done) done_a <= done_a + 1;
  end

  function automatic beat_t mk(int x, int y, int c, int i);
    return '{x: 5'(x), y: 5'(y), code: 2'(c), idx: 8'(i)};
  endfunction

  task automatic set_a(int i, int x, int y);
    snake_in[i*8 +: 8] = {4'(y), 4'(x)};
  endtask

  task automatic set_b(int i, int x, int y);
    b_in[i*10 +: 10] = {5'(y), 5'(x)};
  endtask

  task automatic pulse_a();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_b();
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({a_valid, a_busy, a_done, a_x, a_y, a_data, a_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got %0h want 0",
               {a_valid, a_busy, a_done, a_x, a_y, a_data, a_idx});
    end
    n_checks++;
    if ({b_valid, b_busy, b_done, b_x, b_y, b_data, b_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got %0h want 0",
               {b_valid, b_busy, b_done, b_x, b_y, b_data, b_idx});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (hs_a !== 0) begin
      n_fail++;
      $display("FAIL idle_no_beats: got %0d want 0", hs_a);
    end
  endtask

  task automatic test_basic();
    sb.delete();
    set_a(0, 1, 2); set_a(1, 3, 4); set_a(2, 5, 6);
    snake_len = 3; erase = 0; wr_ready = 1;
    sb.push_back(mk(1, 2, 3, 0));
    sb.push_back(mk(3, 4, 2, 1));
    sb.push_back(mk(5, 6, 2, 2));
    pulse_a();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({a_valid, a_x, a_y, a_data, a_idx} !==
          {1'b1, e.x[3:0], e.y[3:0], e.code, e.idx}) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got %0h want %0h", k,
                 {a_valid, a_x, a_y, a_data, a_idx},
                 {1'b1, e.x[3:0], e.y[3:0], e.code, e.idx});
      end
    end
    @(negedge clk);
    n_checks++;
    if ({a_valid, a_done, a_busy} !== 3'b011) begin
      n_fail++;
      $display("FAIL basic_done: got %b want 011",
               {a_valid, a_done, a_busy});
    end
    @(negedge clk);
    n_checks++;
    if ({a_valid, a_done, a_busy, a_data, a_x, a_y} !==
        {5'b0, 4'd5, 4'd6}) begin
      n_fail++;
      $display("FAIL basic_idle: got %0h want %0h",
               {a_valid, a_done, a_busy, a_data, a_x, a_y},
               {5'b0, 4'd5, 4'd6});
    end
  endtask

  task automatic test_backpressure();
    int h0;
    sb.delete();
    h0 = hs_a;
    set_a(0, 7, 8); set_a(1, 9, 10);
    snake_len = 2; wr_ready = 0;
    sb.push_back(mk(7, 8, 3, 0));
    sb.push_back(mk(9, 10, 2, 1));
    pulse_a();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = sb[0];
      n_checks++;
      if ({a_valid, a_x, a_y, a_data, a_idx} !==
          {1'b1, e.x[3:0], e.y[3:0], e.code, e.idx}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got %0h want %0h", i,
                 {a_valid, a_x, a_y, a_data, a_idx},
                 {1'b1, e.x[3:0], e.y[3:0], e.code, e.idx});
      end
      if (i == 3) wr_ready = 1;
    end
    void'(sb.pop_front());
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({a_valid, a_x, a_y, a_data, a_idx} !==
        {1'b1, e.x[3:0], e.y[3:0], e.code, e.idx}) begin
      n_fail++;
      $display("FAIL bp_beat1: got %0h want %0h",
               {a_valid, a_x, a_y, a_data, a_idx},
               {1'b1, e.x[3:0], e.y[3:0], e.code, e.idx});
    end
    @(negedge clk);
    n_checks++;
    if (a_done !== 1'b1 || hs_a - h0 !== 2) begin
      n_fail++;
      $display("FAIL bp_done: got done=%b hs=%0d want done=1 hs=2",
               a_done, hs_a - h0);
    end
    @(negedge clk);
  endtask

  task automatic test_erase_empty();
    int h0;
    sb.delete();
    set_a(0, 11, 12); set_a(1, 13, 14);
    snake_len = 2; erase = 1; wr_ready = 1;
    sb.push_back(mk(11, 12, 0, 0));
    sb.push_back(mk(13, 14, 0, 1));
    pulse_a();
    erase = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({a_valid, a_x, a_y, a_data, a_idx} !==
          {1'b1, e.x[3:0], e.y[3:0], e.code, e.idx}) begin
        n_fail++;
        $display("FAIL erase_beat%0d: got %0h want %0h", k,
                 {a_valid, a_x, a_y, a_data, a_idx},
                 {1'b1, e.x[3:0], e.y[3:0], e.code, e.idx});
      end
    end
    repeat (2) @(negedge clk);
    h0 = hs_a;
    snake_len = 0;
    pulse_a();
    @(negedge clk);
    n_checks++;
    if ({a_valid, a_done, a_busy} !== 3'b011) begin
      n_fail++;
      $display("FAIL empty_done: got %b want 011",
               {a_valid, a_done, a_busy});
    end
    @(negedge clk);
    n_checks++;
    if ({a_valid, a_done, a_busy} !== 3'b000 || hs_a !== h0) begin
      n_fail++;
      $display("FAIL empty_after: got %b hs=%0d want 000 hs=%0d",
               {a_valid, a_done, a_busy}, hs_a, h0);
    end
  endtask

  task automatic test_clamp_max();
    sb.delete();
    set_b(0, 31, 31); set_b(1, 1, 2); set_b(2, 3, 4); set_b(3, 30, 0);
    b_len = 9; b_ready = 1;
    sb.push_back(mk(31, 31, 3, 0));
    sb.push_back(mk(1, 2, 2, 1));
    sb.push_back(mk(3, 4, 2, 2));
    sb.push_back(mk(30, 0, 2, 3));
    pulse_b();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({b_valid, b_x, b_y, b_data, b_idx} !==
          {1'b1, e.x, e.y, e.code, e.idx[3:0]}) begin
        n_fail++;
        $display("FAIL clamp_beat%0d: got %0h want %0h", k,
                 {b_valid, b_x, b_y, b_data, b_idx},
                 {1'b1, e.x, e.y, e.code, e.idx[3:0]});
      end
    end
    @(negedge clk);
    n_checks++;
    if ({b_valid, b_done, b_idx} !== {2'b01, 4'd3}) begin
      n_fail++;
      $display("FAIL clamp_done: got %0h want %0h",
               {b_valid, b_done, b_idx}, {2'b01, 4'd3});
    end
    @(negedge clk);
  endtask

  task automatic test_snapshot();
    int d0;
    sb.delete();
    set_a(0, 2, 3); set_a(1, 4, 5); set_a(2, 6, 7);
    snake_len = 3; erase = 0; wr_ready = 1;
    sb.push_back(mk(2, 3, 3, 0));
    sb.push_back(mk(4, 5, 2, 1));
    sb.push_back(mk(6, 7, 2, 2));
    d0 = done_a;
    pulse_a();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({a_valid, a_x, a_y, a_data, a_idx} !==
          {1'b1, e.x[3:0], e.y[3:0], e.code, e.idx}) begin
        n_fail++;
        $display("FAIL snap_beat%0d: got %0h want %0h", k,
                 {a_valid, a_x, a_y, a_data, a_idx},
                 {1'b1, e.x[3:0], e.y[3:0], e.code, e.idx});
      end
      if (k == 0) begin
        set_a(1, 15, 15); set_a(2, 15, 15);
        erase = 1; snake_len = 1; start = 1;
      end
    end
    @(negedge clk);
    @(negedge clk) start = 0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_a - d0 !== 1 || a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL snap_one_done: got %0d valid=%b want 1 valid=0",
               done_a - d0, a_valid);
    end
    erase = 0;
  endtask

  task automatic test_reset_mid_walk();
    int h0;
    bit seen;
    snake_len = 5; wr_ready = 1;
    pulse_a();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_valid, a_busy, a_done, a_idx} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %0h want 0",
               {a_valid, a_busy, a_done, a_idx});
    end
    @(negedge clk) rst_n = 1'b1;
    h0 = hs_a;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (a_valid) seen = 1;
    end
    n_checks++;
    if (seen !== 1'b0 || hs_a !== h0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: got seen=%b hs=%0d want 0 %0d",
               seen, hs_a, h0);
    end
  endtask

  initial begin
    start = 0; erase = 0; wr_ready = 1;
    snake_len = 0; snake_in = '0;
    b_start = 0; b_erase = 0; b_ready = 1;
    b_len = 0; b_in = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_erase_empty();
    test_clamp_max();
    test_snapshot();
    test_reset_mid_walk();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
